booth_mul_seq: RTL
==================

# booth_mul_seq

Sequential signed multiplier for the datapath's MUL instruction, the counterpart to the restoring divider. It takes two signed WIDTH-bit operands on a start pulse and runs one Booth recoding step per clock. It returns the 2·WIDTH-bit product packed as {HI, LO}, in the same layout the divider uses for {quotient, remainder}, so the HI/LO register load path is shared. A busy/done handshake lets the control unit stall until the result is ready.

## Interface

- WIDTH, 32, operand width in bits; must be even, and ≥ 4.
- clock  input  1  rising-edge clock.
- clear  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while busy = 0.
- a  input  WIDTH  signed multiplicand, latched on an accepted start.
- b  input  WIDTH  signed multiplier, latched on an accepted start.
- p  output  2·WIDTH  signed product; p[2W-1:W] → HI, p[W-1:0] → LO.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse marking the cycle p first holds a new result.

## Operation

- States are IDLE, RUN and DONE. busy = 1 only in RUN.
- IDLE / DONE with start = 1:
  - latch M ← a.
  - Q ← b.
  - accumulator A ← 0 (WIDTH+1 bits).
  - Q₋₁ ← 0.
  - step counter ← WIDTH.
  - go to RUN.
- IDLE / DONE with start = 0: go to IDLE (DONE always lasts exactly one cycle).
- Each RUN cycle does one radix-2 Booth step on the pair (Q[0], Q₋₁):
  - 01: A ← A + M.
  - 10: A ← A − M.
  - 00 or 11: A unchanged.
  - Then arithmetic-shift {A, Q, Q₋₁} right by 1 and decrement the counter.
- Arithmetic width:
  - M is sign-extended to WIDTH+1 bits before the add/sub, so M = −2^(W−1) is exact.
  - Final product = {A[W-1:0], Q}.
- On the last step (counter reaches 0):
  - p ← product.
  - done ← 1.
  - go to DONE.
- p holds its value through RUN and IDLE. It changes only at completion or on clear.
- start while busy = 1 is ignored. Operands and the in-flight result are unaffected.
- a and b are don't-care except in the cycle start is accepted.

## Timing

- Reset values (clear = 1, asynchronous):
  - state = IDLE.
  - p = 0.
  - busy = 0.
  - done = 0.
  - A, Q, Q₋₁ and counter = 0.
- Accept edge E0: start = 1 with busy = 0. busy is 1 after E0.
- Latency: WIDTH RUN edges (E1…E_WIDTH). After E_WIDTH, p is valid, done = 1 and busy = 0.
  - WIDTH = 32 gives a start-to-done latency of 32 cycles.
- Edge E_WIDTH+1: done = 0. If start = 1 in the DONE cycle, a new operation is accepted, giving back-to-back throughput of one result per WIDTH+1 cycles.
- clear mid-RUN:
  - aborts immediately to the reset values.
  - done does not pulse for the aborted operation.
  - the first start after clear deasserts is accepted normally.
- Deassertion of clear is synchronized externally; the block uses no internal synchronizer.

## Configuration

- BOOTH_RADIX4_EN undefined: radix-2 as above, WIDTH RUN cycles.
- BOOTH_RADIX4_EN defined: radix-4 (modified Booth), recoding triplet (Q[1], Q[0], Q₋₁):
  - 001 / 010: +M.
  - 011: +2M.
  - 100: −2M.
  - 101 / 110: −M.
  - 000 / 111: 0.
  - A widens to WIDTH+2 bits.
  - Each step arithmetic-shifts {A, Q, Q₋₁} right by 2.
  - Counter ← WIDTH/2, so latency is WIDTH/2 cycles (16 at WIDTH = 32).
- The handshake, reset values and p layout are identical in both modes, and results are bit-identical.

## Test plan

- a = 7, b = 3, start for 1 cycle → busy for 32 cycles, then done pulse with p = 0x0000_0000_0000_0015. p stays stable afterward.
- a = −7, b = 3 → p = 0xFFFF_FFFF_FFFF_FFEB. Also a = −7, b = −3 → p = 0x15.
- Corner operands:
  - a = 0x8000_0000, b = 0x8000_0000 → p = 0x4000_0000_0000_0000.
  - a = 0x7FFF_FFFF, b = 0x8000_0000 → p = 0xC000_0000_8000_0000.
  - a = 0, b = 0xFFFF_FFFF → p = 0.
- Start 5 × 6, then re-assert start with a = 9, b = 9 at RUN cycle 10 → second start ignored, p = 0x1E. Then start 9 × 9 in the DONE cycle → p = 0x51 exactly 33 cycles after the first result.
- Start 1000 × 1000, assert clear at RUN cycle 10 → busy = 0, p = 0 and no done pulse. Next start 2 × −2 → p = 0xFFFF_FFFF_FFFF_FFFC.
- With BOOTH_RADIX4_EN defined, rerun scenarios 1–3 → identical p values, done 16 cycles after the accept edge.

Source files
------------

// File: rtl/booth_mul_seq_if.sv
// Operand/result handshake bundle for the sequential Booth multiplier.
// The control unit holds the master side and the multiplier holds the slave side.
interface booth_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] p;
    logic               busy;
    logic               done;

    modport master (output start, a, b, input  p, busy, done);
    modport slave  (input  start, a, b, output p, busy, done);
endinterface

// File: rtl/booth_mul_seq.sv
// Sequential signed Booth multiplier. The product is packed as {HI, LO} in p.
// Define BOOTH_RADIX4_EN for modified-Booth recoding: two bits per step, WIDTH/2 steps.
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          clear,
    booth_mul_seq_if.slave bus
);
`ifdef BOOTH_RADIX4_EN
    localparam int AW    = WIDTH + 2;
    localparam int STEPS = WIDTH / 2;
`else
    localparam int AW    = WIDTH + 1;
    localparam int STEPS = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [AW-1:0]      acc_r, acc_s;
    logic [WIDTH-1:0]   q_r, q_s;
    logic               qm1_r, qm1_s;
    logic [WIDTH-1:0]   m_r, m_s;
    logic [CW-1:0]      cnt_r, cnt_s;
    logic [2*WIDTH-1:0] p_r, p_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic [AW-1:0]      mext_s;
    logic [AW-1:0]      sum_s;

    assign bus.p    = p_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

    // State and datapath registers; clear returns everything to idle at once.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r <= IDLE;
            acc_r   <= {AW{1'b0}};
            q_r     <= {WIDTH{1'b0}};
            qm1_r   <= 1'b0;
            m_r     <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            p_r     <= {(2*WIDTH){1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            q_r     <= q_s;
            qm1_r   <= qm1_s;
            m_r     <= m_s;
            cnt_r   <= cnt_s;
            p_r     <= p_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state, Booth step and registered-output logic.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        q_s     = q_r;
        qm1_s   = qm1_r;
        m_s     = m_r;
        cnt_s   = cnt_r;
        p_s     = p_r;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        // Sign-extending M keeps -2^(W-1) (and 2M in radix-4) exact in the accumulator.
        mext_s  = {{(AW-WIDTH){m_r[WIDTH-1]}}, m_r};
        sum_s   = acc_r;

        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    m_s     = bus.a;
                    q_s     = bus.b;
                    acc_s   = {AW{1'b0}};
                    qm1_s   = 1'b0;
                    cnt_s   = CW'(STEPS);
                    busy_s  = 1'b1;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
`ifdef BOOTH_RADIX4_EN
                case ({q_r[1:0], qm1_r})
                    3'b001, 3'b010: sum_s = acc_r + mext_s;
                    3'b011:         sum_s = acc_r + {mext_s[AW-2:0], 1'b0};
                    3'b100:         sum_s = acc_r - {mext_s[AW-2:0], 1'b0};
                    3'b101, 3'b110: sum_s = acc_r - mext_s;
                    default:        sum_s = acc_r;
                endcase
                acc_s = {{2{sum_s[AW-1]}}, sum_s[AW-1:2]};
                q_s   = {sum_s[1:0], q_r[WIDTH-1:2]};
                qm1_s = q_r[1];
`else
                case ({q_r[0], qm1_r})
                    2'b01:   sum_s = acc_r + mext_s;
                    2'b10:   sum_s = acc_r - mext_s;
                    default: sum_s = acc_r;
                endcase
                acc_s = {sum_s[AW-1], sum_s[AW-1:1]};
                q_s   = {sum_s[0], q_r[WIDTH-1:1]};
                qm1_s = q_r[0];
`endif
                cnt_s = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    p_s     = {acc_s[WIDTH-1:0], q_s};
                    done_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    busy_s  = 1'b1;
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end
endmodule
